// File: rtl/array_injector_2x2.sv
// Host-to-array feeder: one word stream split into two paced column FIFOs driving fill1/fill2.
// Optional per-column fill counters (inj_cnt1/inj_cnt2) are enabled by defining ARRAY_INJ_CNT_EN.
module array_injector_2x2 #(
  parameter int unsigned data_size  = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_col,
  input  logic [data_size-1:0]          in_data,
  output logic                          fill1,
  output logic [data_size-1:0]          o_data1,
  output logic                          fill2,
  output logic [data_size-1:0]          o_data2,
  output logic [$clog2(FIFO_DEPTH):0]   col1_level,
  output logic [$clog2(FIFO_DEPTH):0]   col2_level
`ifdef ARRAY_INJ_CNT_EN
  ,
  output logic [15:0]                   inj_cnt1,
  output logic [15:0]                   inj_cnt2
`endif
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
  localparam int unsigned GapW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StGap} state_e;

  for (genvar c = 0; c < 2; c++) begin : g_col
    logic                 push, pop, full, empty, can_issue;
    logic [LvlW-1:0]      wr_q, rd_q, level;
    logic [data_size-1:0] mem_q [FIFO_DEPTH];
    state_e               state_q, state_d;
    logic [GapW-1:0]      gap_q, gap_d;
    logic                 fill_q, fill_d;
    logic [data_size-1:0] data_q, data_d;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign level = wr_q - rd_q;
    assign full  = (level == LvlW'(FIFO_DEPTH));
    assign empty = (level == '0);
    assign push  = in_valid && (in_col == 1'(c)) && !full;

    always_comb begin
      state_d   = state_q;
      gap_d     = gap_q;
      fill_d    = 1'b0;
      data_d    = '0;
      pop       = 1'b0;
      can_issue = 1'b0;
      unique case (state_q)
        StIdle: can_issue = 1'b1;
        StIssue: begin
          if (GAP_CYCLES == 0) begin
            state_d   = StIdle;
            can_issue = 1'b1;
          end else begin
            gap_d   = GapW'(GAP_CYCLES);
            state_d = StGap;
          end
        end
        StGap: begin
          gap_d = gap_q - GapW'(1);
          // Last gap cycle may pop so the next fill lands exactly GAP_CYCLES idle cycles later.
          if (gap_q == GapW'(1)) begin
            state_d   = StIdle;
            can_issue = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
      if (can_issue && en && !empty) begin
        pop     = 1'b1;
        fill_d  = 1'b1;
        data_d  = mem_q[rd_q[PtrW-1:0]];
        state_d = StIssue;
      end
    end

    always_ff @(posedge clk) begin
      if (push) mem_q[wr_q[PtrW-1:0]] <= in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_q    <= '0;
        rd_q    <= '0;
        state_q <= StIdle;
        gap_q   <= '0;
        fill_q  <= 1'b0;
        data_q  <= '0;
      end else begin
        if (push) wr_q <= wr_q + LvlW'(1);
        if (pop)  rd_q <= rd_q + LvlW'(1);
        state_q <= state_d;
        gap_q   <= gap_d;
        fill_q  <= fill_d;
        data_q  <= data_d;
      end
    end

`ifdef ARRAY_INJ_CNT_EN
    logic [15:0] cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      cnt_q <= '0;
      else if (fill_q) cnt_q <= cnt_q + 16'd1;
    end
`endif
  end

  assign in_ready   = in_col ? !g_col[1].full : !g_col[0].full;
  assign fill1      = g_col[0].fill_q;
  assign o_data1    = g_col[0].data_q;
  assign fill2      = g_col[1].fill_q;
  assign o_data2    = g_col[1].data_q;
  assign col1_level = g_col[0].level;
  assign col2_level = g_col[1].level;
`ifdef ARRAY_INJ_CNT_EN
  assign inj_cnt1   = g_col[0].cnt_q;
  assign inj_cnt2   = g_col[1].cnt_q;
`endif

endmodule

// File: tb/tb_array_injector_2x2.sv
// Directed table-driven bench for array_injector_2x2 (default parameters: depth 4, gap 1).
module tb_array_injector_2x2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, in_valid, in_col;
  logic       in_ready;
  logic [7:0] in_data;
  logic       fill1, fill2;
  logic [7:0] o_data1, o_data2;
  logic [2:0] col1_level, col2_level;
`ifdef ARRAY_INJ_CNT_EN
  logic [15:0] inj_cnt1, inj_cnt2;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  array_injector_2x2 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_col     (in_col),
    .in_data    (in_data),
    .fill1      (fill1),
    .o_data1    (o_data1),
    .fill2      (fill2),
    .o_data2    (o_data2),
    .col1_level (col1_level),
    .col2_level (col2_level)
`ifdef ARRAY_INJ_CNT_EN
    ,
    .inj_cnt1   (inj_cnt1),
    .inj_cnt2   (inj_cnt2)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en, vld, col;
    logic [7:0] din;
    logic       rdy, f1;
    logic [7:0] d1;
    logic       f2;
    logic [7:0] d2;
    logic [2:0] l1, l2;
  } vec_t;

  localparam int NVec = 26;
  vec_t vecs [NVec];

  function automatic vec_t mk(logic e, logic v, logic c, logic [7:0] di, logic r, logic f1,
                              logic [7:0] d1, logic f2, logic [7:0] d2, logic [2:0] l1,
                              logic [2:0] l2);
    vec_t t;
    t.en = e; t.vld = v; t.col = c; t.din = di; t.rdy = r;
    t.f1 = f1; t.d1 = d1; t.f2 = f2; t.d2 = d2; t.l1 = l1; t.l2 = l2;
    return t;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " fill1"}, 16'(fill1), 16'h0);
    chk({tag, " o_data1"}, 16'(o_data1), 16'h0);
    chk({tag, " fill2"}, 16'(fill2), 16'h0);
    chk({tag, " o_data2"}, 16'(o_data2), 16'h0);
    chk({tag, " col1_level"}, 16'(col1_level), 16'h0);
    chk({tag, " col2_level"}, 16'(col2_level), 16'h0);
  endtask

  initial begin
    //                 en vld col din    rdy f1 d1     f2 d2     l1 l2
    vecs[0]  = mk(1, 1, 0, 8'hA5, 1, 0, 8'h00, 0, 8'h00, 0, 0);
    vecs[1]  = mk(1, 0, 0, 8'h00, 1, 0, 8'h00, 0, 8'h00, 1, 0);
    vecs[2]  = mk(1, 0, 0, 8'h00, 1, 1, 8'hA5, 0, 8'h00, 0, 0);
    vecs[3]  = mk(1, 1, 1, 8'h11, 1, 0, 8'h00, 0, 8'h00, 0, 0);
    vecs[4]  = mk(1, 1, 1, 8'h22, 1, 0, 8'h00, 0, 8'h00, 0, 1);
    vecs[5]  = mk(1, 1, 1, 8'h33, 1, 0, 8'h00, 1, 8'h11, 0, 1);
    vecs[6]  = mk(1, 0, 0, 8'h00, 1, 0, 8'h00, 0, 8'h00, 0, 2);
    vecs[7]  = mk(1, 0, 0, 8'h00, 1, 0, 8'h00, 1, 8'h22, 0, 1);
    vecs[8]  = mk(1, 0, 0, 8'h00, 1, 0, 8'h00, 0, 8'h00, 0, 1);
    vecs[9]  = mk(1, 0, 0, 8'h00, 1, 0, 8'h00, 1, 8'h33, 0, 0);
    vecs[10] = mk(0, 1, 0, 8'h01, 1, 0, 8'h00, 0, 8'h00, 0, 0);
    vecs[11] = mk(0, 1, 0, 8'h02, 1, 0, 8'h00, 0, 8'h00, 1, 0);
    vecs[12] = mk(0, 1, 0, 8'h03, 1, 0, 8'h00, 0, 8'h00, 2, 0);
    vecs[13] = mk(0, 1, 0, 8'h04, 1, 0, 8'h00, 0, 8'h00, 3, 0);
    vecs[14] = mk(0, 1, 0, 8'h05, 0, 0, 8'h00, 0, 8'h00, 4, 0);
    vecs[15] = mk(0, 1, 1, 8'h77, 1, 0, 8'h00, 0, 8'h00, 4, 0);
    vecs[16] = mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 4, 1);
    vecs[17] = mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 4, 1);
    vecs[18] = mk(0, 0, 0, 8'h00, 1, 1, 8'h01, 1, 8'h77, 3, 0);
    vecs[19] = mk(0, 0, 0, 8'h00, 1, 0, 8'h00, 0, 8'h00, 3, 0);
    vecs[20] = mk(0, 0, 0, 8'h00, 1, 0, 8'h00, 0, 8'h00, 3, 0);
    vecs[21] = mk(1, 0, 0, 8'h00, 1, 0, 8'h00, 0, 8'h00, 3, 0);
    vecs[22] = mk(1, 0, 0, 8'h00, 1, 1, 8'h02, 0, 8'h00, 2, 0);
    vecs[23] = mk(1, 0, 0, 8'h00, 1, 0, 8'h00, 0, 8'h00, 2, 0);
    vecs[24] = mk(0, 0, 0, 8'h00, 1, 1, 8'h03, 0, 8'h00, 1, 0);
    vecs[25] = mk(0, 0, 0, 8'h00, 1, 0, 8'h00, 0, 8'h00, 1, 0);

    // Reset held with in_valid asserted: nothing may be stored or issued.
    rst_n = 1'b0; en = 1'b1; in_valid = 1'b1; in_col = 1'b0; in_data = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_col = i[0];
      #1;
      chk_idle_outputs("reset");
      chk("reset in_ready", 16'(in_ready), 16'h1);
    end

    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;

    for (int i = 0; i < NVec; i++) begin
      @(negedge clk);
      en = vecs[i].en; in_valid = vecs[i].vld; in_col = vecs[i].col; in_data = vecs[i].din;
      #1;
      chk($sformatf("v%0d in_ready", i), 16'(in_ready), 16'(vecs[i].rdy));
      chk($sformatf("v%0d fill1", i), 16'(fill1), 16'(vecs[i].f1));
      chk($sformatf("v%0d o_data1", i), 16'(o_data1), 16'(vecs[i].d1));
      chk($sformatf("v%0d fill2", i), 16'(fill2), 16'(vecs[i].f2));
      chk($sformatf("v%0d o_data2", i), 16'(o_data2), 16'(vecs[i].d2));
      chk($sformatf("v%0d col1_level", i), 16'(col1_level), 16'(vecs[i].l1));
      chk($sformatf("v%0d col2_level", i), 16'(col2_level), 16'(vecs[i].l2));
    end

`ifdef ARRAY_INJ_CNT_EN
    @(negedge clk);
    en = 1'b0; in_valid = 1'b0;
    #1;
    chk("inj_cnt1 after table", inj_cnt1, 16'd4);
    chk("inj_cnt2 after table", inj_cnt2, 16'd4);
`endif

    // Top column 0 back up to three buffered words, then reset mid-cycle.
    @(negedge clk);
    en = 1'b0; in_valid = 1'b1; in_col = 1'b0; in_data = 8'hC1;
    @(negedge clk);
    in_data = 8'hC2;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("pre-reset col1_level", 16'(col1_level), 16'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset col1_level", 16'(col1_level), 16'd0);
    chk("async reset col2_level", 16'(col2_level), 16'd0);
    chk("async reset in_ready", 16'(in_ready), 16'h1);
`ifdef ARRAY_INJ_CNT_EN
    chk("async reset inj_cnt1", inj_cnt1, 16'd0);
    chk("async reset inj_cnt2", inj_cnt2, 16'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      chk_idle_outputs($sformatf("post-reset c%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
